fetch_stage: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline: owns the PC, drives the icache request, buffers a returned

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_if.sv | 49 ++++
 rtl/fetch_stage_ifid_latch.sv | 38 +++
 rtl/fetch_stage.sv | 145 ++++++++++++++
 tb/tb_fetch_stage.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared CPU types for the fetch stage: word/opcode/funct types, the fetch
// FSM encoding and the fetch constants.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [5:0]  opcode_t;
  typedef logic [5:0]  funct_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t WBYTES    = 32'd4;
  localparam word_t NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: icache request/response, hazard unit controls and the
// IF/ID latch outputs. The master modport is the fetch stage's view.
// Optional FETCH_PERF_EN adds the fetch_cnt/stall_cnt performance counters.
interface fetch_stage_if;
  import cpu_types_pkg::*;

  logic    ihit;
  word_t   iload;
  logic    iREN;
  word_t   iaddr;
  logic    hazard;
  logic    branch;
  logic    jump;
  word_t   branch_target;
  word_t   jump_target;
  logic    mem_stall;
  logic    halt;
  word_t   ifid_instr;
  word_t   ifid_npc;
  logic    ifid_valid;
  opcode_t instrOp;
  funct_t  instrFunc;
  logic    halted;
`ifdef FETCH_PERF_EN
  word_t   fetch_cnt;
  word_t   stall_cnt;
`endif

  modport master (
    input  ihit, iload, hazard, branch, jump, branch_target, jump_target,
           mem_stall, halt,
`ifdef FETCH_PERF_EN
    output fetch_cnt, stall_cnt,
`endif
    output iREN, iaddr, ifid_instr, ifid_npc, ifid_valid, instrOp,
           instrFunc, halted
  );

  modport slave (
    output ihit, iload, hazard, branch, jump, branch_target, jump_target,
           mem_stall, halt,
`ifdef FETCH_PERF_EN
    input  fetch_cnt, stall_cnt,
`endif
    input  iREN, iaddr, ifid_instr, ifid_npc, ifid_valid, instrOp,
           instrFunc, halted
  );

endinterface

// File: rtl/fetch_stage_ifid_latch.sv
// IF/ID pipeline register. Load captures a real instruction, flush inserts
// a NOP bubble, neither holds the current contents.
module ifid_latch
  import cpu_types_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_load,
  input  logic  i_flush,
  input  word_t i_instr,
  input  word_t i_npc,
  output word_t o_instr,
  output word_t o_npc,
  output logic  o_valid
);

  word_t r_instr;
  word_t r_npc;
  logic  r_valid;

  // Latch update: flush outranks load so a redirect always leaves a bubble
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_instr <= NOP_INSTR;
      r_npc   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_npc   <= i_npc;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_npc   = r_npc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, the fetch FSM, the held-instruction buffer and the
// redirect mux; the IF/ID register lives in ifid_latch.
// Optional FETCH_PERF_EN adds saturating fetch/stall counters.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
)(
  input logic           CLK,
  input logic           RST,
  fetch_stage_if.master bus
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  word_t        r_pc;
  word_t        r_held_instr;
  word_t        r_held_npc;

  logic  w_stall;
  logic  w_redirect;
  word_t w_pc_plus4;
  word_t w_target;
  word_t w_pc_next;
  logic  w_latch_load;
  logic  w_latch_flush;
  word_t w_latch_instr;
  word_t w_latch_npc;
  logic  w_held_load;

  assign w_stall    = bus.hazard | bus.mem_stall;
  assign w_redirect = bus.jump | bus.branch;
  assign w_pc_plus4 = r_pc + WBYTES;
  assign w_target   = (bus.jump ? bus.jump_target : bus.branch_target) & ~32'd3;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= FETCH;
    else     r_state <= w_next_state;
  end

  // Next state: halt > stall > redirect > normal; only reset leaves HALTED
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      HALTED:  w_next_state = HALTED;
      FETCH, HOLD: begin
        if (bus.halt && !bus.mem_stall)
          w_next_state = HALTED;
        else if (w_stall)
          w_next_state = (r_state == FETCH && bus.ihit) ? HOLD : r_state;
        else
          w_next_state = FETCH;
      end
      default: w_next_state = FETCH;
    endcase
  end

  // FSM outputs: the icache is only read while actively fetching
  always_comb begin
    bus.iREN = (r_state == FETCH);
  end

  // Datapath control: PC, IF/ID latch and held buffer steering
  always_comb begin
    w_pc_next     = r_pc;
    w_latch_load  = 1'b0;
    w_latch_flush = 1'b0;
    w_latch_instr = bus.iload;
    w_latch_npc   = w_pc_plus4;
    w_held_load   = 1'b0;
    if (r_state == HALTED || (bus.halt && !bus.mem_stall)) begin
      w_latch_flush = 1'b1;
    end else if (w_stall) begin
      w_held_load = (r_state == FETCH) && bus.ihit;
    end else if (w_redirect) begin
      w_pc_next     = w_target;
      w_latch_flush = 1'b1;
    end else if (r_state == HOLD) begin
      w_latch_load  = 1'b1;
      w_latch_instr = r_held_instr;
      w_latch_npc   = r_held_npc;
      w_pc_next     = r_held_npc;
    end else if (bus.ihit) begin
      w_latch_load = 1'b1;
      w_pc_next    = w_pc_plus4;
    end else begin
      w_latch_flush = 1'b1;
    end
  end

  // PC and held buffer; held contents are simply ignored after a redirect
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc         <= PC_INIT;
      r_held_instr <= NOP_INSTR;
      r_held_npc   <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_held_load) begin
        r_held_instr <= bus.iload;
        r_held_npc   <= w_pc_plus4;
      end
    end
  end

  ifid_latch u_ifid (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_load  (w_latch_load),
    .i_flush (w_latch_flush),
    .i_instr (w_latch_instr),
    .i_npc   (w_latch_npc),
    .o_instr (bus.ifid_instr),
    .o_npc   (bus.ifid_npc),
    .o_valid (bus.ifid_valid)
  );

  assign bus.iaddr     = r_pc;
  assign bus.instrOp   = bus.ifid_instr[31:26];
  assign bus.instrFunc = bus.ifid_instr[5:0];
  assign bus.halted    = (r_state == HALTED);

`ifdef FETCH_PERF_EN
  word_t r_fetch_cnt;
  word_t r_stall_cnt;

  // Saturating counters: valid IF/ID writes and stalled cycles outside HALTED
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_latch_load && r_fetch_cnt != 32'hFFFF_FFFF)
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_stall && r_state != HALTED && r_stall_cnt != 32'hFFFF_FFFF)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.fetch_cnt = r_fetch_cnt;
  assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming fetch, hazard park/unpark,
// redirects, PC wrap, hazard-masked redirect, halt behind mem_stall, reset.
module tb_fetch_stage;
  import cpu_types_pkg::*;

  logic CLK;
  logic RST;
  int   total;
  int   bad;

  fetch_stage_if bus_if ();

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one clock and settle just after the active edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST = 1'b1;
    bus_if.ihit = 1'b0;          bus_if.iload = '0;
    bus_if.hazard = 1'b0;        bus_if.branch = 1'b0;
    bus_if.jump = 1'b0;          bus_if.branch_target = '0;
    bus_if.jump_target = '0;     bus_if.mem_stall = 1'b0;
    bus_if.halt = 1'b0;
    step();
    step();
    RST = 1'b0;
    check("rst_iaddr",  bus_if.iaddr, 32'h0);
    check("rst_valid",  32'(bus_if.ifid_valid), 32'h0);
    check("rst_instr",  bus_if.ifid_instr, 32'h0);
    check("rst_npc",    bus_if.ifid_npc, 32'h0);
    check("rst_halted", 32'(bus_if.halted), 32'h0);
    check("rst_iren",   32'(bus_if.iREN), 32'h1);

    // Streaming fetch
    bus_if.ihit = 1'b1; bus_if.iload = 32'h2001_0005;
    step();
    check("f1_valid", 32'(bus_if.ifid_valid), 32'h1);
    check("f1_instr", bus_if.ifid_instr, 32'h2001_0005);
    check("f1_npc",   bus_if.ifid_npc, 32'h4);
    check("f1_iaddr", bus_if.iaddr, 32'h4);
    check("f1_op",    32'(bus_if.instrOp), 32'h08);
    check("f1_func",  32'(bus_if.instrFunc), 32'h05);
    step();
    check("f2_iaddr", bus_if.iaddr, 32'h8);
    check("f2_npc",   bus_if.ifid_npc, 32'h8);

    // Hazard with ihit at PC=8: park, hold for 3 cycles, then release
    bus_if.hazard = 1'b1; bus_if.iload = 32'hAAAA_0001;
    step();
    check("h1_iren",  32'(bus_if.iREN), 32'h0);
    check("h1_iaddr", bus_if.iaddr, 32'h8);
    check("h1_instr", bus_if.ifid_instr, 32'h2001_0005);
    check("h1_npc",   bus_if.ifid_npc, 32'h8);
    bus_if.ihit = 1'b0; bus_if.iload = 32'h0;
    step();
    step();
    check("h3_iren",  32'(bus_if.iREN), 32'h0);
    check("h3_iaddr", bus_if.iaddr, 32'h8);
    check("h3_instr", bus_if.ifid_instr, 32'h2001_0005);
    bus_if.hazard = 1'b0;
    step();
    check("hr_instr", bus_if.ifid_instr, 32'hAAAA_0001);
    check("hr_npc",   bus_if.ifid_npc, 32'hC);
    check("hr_valid", 32'(bus_if.ifid_valid), 32'h1);
    check("hr_iaddr", bus_if.iaddr, 32'hC);
    check("hr_iren",  32'(bus_if.iREN), 32'h1);

    // No ihit, no stall: bubble
    step();
    check("bub_valid", 32'(bus_if.ifid_valid), 32'h0);
    check("bub_instr", bus_if.ifid_instr, 32'h0);
    check("bub_iaddr", bus_if.iaddr, 32'hC);

    // Branch with concurrent ihit, target low bits forced to zero
    bus_if.branch = 1'b1; bus_if.branch_target = 32'h0000_0043;
    bus_if.ihit = 1'b1; bus_if.iload = 32'h1234_5678;
    step();
    check("br_iaddr", bus_if.iaddr, 32'h40);
    check("br_valid", 32'(bus_if.ifid_valid), 32'h0);
    check("br_instr", bus_if.ifid_instr, 32'h0);

    // Jump and branch together: jump wins
    bus_if.jump = 1'b1; bus_if.jump_target = 32'h100; bus_if.branch_target = 32'h200;
    step();
    check("jb_iaddr", bus_if.iaddr, 32'h100);
    check("jb_valid", 32'(bus_if.ifid_valid), 32'h0);
    bus_if.branch = 1'b0;

    // PC wrap
    bus_if.jump_target = 32'hFFFF_FFFC; bus_if.ihit = 1'b0;
    step();
    check("wr_pre_iaddr", bus_if.iaddr, 32'hFFFF_FFFC);
    bus_if.jump = 1'b0; bus_if.ihit = 1'b1; bus_if.iload = 32'h0000_0020;
    step();
    check("wr_iaddr", bus_if.iaddr, 32'h0);
    check("wr_npc",   bus_if.ifid_npc, 32'h0);
    check("wr_instr", bus_if.ifid_instr, 32'h0000_0020);
    check("wr_valid", 32'(bus_if.ifid_valid), 32'h1);

    // Redirect masked by hazard, no ihit: everything holds
    bus_if.hazard = 1'b1; bus_if.jump = 1'b1; bus_if.jump_target = 32'h500;
    bus_if.ihit = 1'b0;
    step();
    check("hm_iaddr", bus_if.iaddr, 32'h0);
    check("hm_valid", 32'(bus_if.ifid_valid), 32'h1);
    check("hm_iren",  32'(bus_if.iREN), 32'h1);
    bus_if.hazard = 1'b0; bus_if.jump = 1'b0;
    bus_if.ihit = 1'b1; bus_if.iload = 32'h0000_0024;
    step();
    check("pre_halt_iaddr", bus_if.iaddr, 32'h4);

    // Halt behind mem_stall for two cycles
    bus_if.ihit = 1'b0; bus_if.halt = 1'b1; bus_if.mem_stall = 1'b1;
    step();
    step();
    check("hs_halted", 32'(bus_if.halted), 32'h0);
    check("hs_iren",   32'(bus_if.iREN), 32'h1);
    check("hs_valid",  32'(bus_if.ifid_valid), 32'h1);
    bus_if.mem_stall = 1'b0;
    step();
    check("ha_halted", 32'(bus_if.halted), 32'h1);
    check("ha_iren",   32'(bus_if.iREN), 32'h0);
    check("ha_valid",  32'(bus_if.ifid_valid), 32'h0);
    check("ha_iaddr",  bus_if.iaddr, 32'h4);
    bus_if.halt = 1'b0; bus_if.ihit = 1'b1; bus_if.iload = 32'h1111_1111;
    step();
    check("hk_halted", 32'(bus_if.halted), 32'h1);
    check("hk_iaddr",  bus_if.iaddr, 32'h4);
    check("hk_valid",  32'(bus_if.ifid_valid), 32'h0);

    // Reset leaves HALTED
    RST = 1'b1; bus_if.ihit = 1'b0;
    step();
    RST = 1'b0;
    check("rr_iaddr",  bus_if.iaddr, 32'h0);
    check("rr_halted", 32'(bus_if.halted), 32'h0);
    check("rr_iren",   32'(bus_if.iREN), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
